// File: rtl/uart_baud_gen_frac.sv
// ----------------------------------------------------------------------------
// uart_baud_gen_frac
// Fractional baud-rate generator. Produces an oversampling strobe whose mean
// period is div_int + div_frac/2^FRAC_W clock cycles, a bit strobe every OVS
// samples and a mid-bit strobe at sample OVS/2. Divisor changes are staged in
// a shadow register and take effect at a period boundary; restart realigns
// the phase to zero for RX start-bit alignment.
//
// Ports
//   clk            clock
//   reset_n        asynchronous active-low reset
//   en_i           count enable; low freezes all counters and silences ticks
//   div_int_i      requested integer divisor
//   div_frac_i     requested fractional divisor
//   load_i         one-cycle pulse, captures div_int_i/div_frac_i
//   restart_i      one-cycle pulse, realigns phase to zero
//   sample_tick_o  one-cycle oversample strobe
//   bit_tick_o     one-cycle strobe every OVS sample ticks
//   mid_tick_o     one-cycle strobe at sample OVS/2 of each bit
//   load_pending_o shadow divisor captured but not yet active
// ----------------------------------------------------------------------------
module uart_baud_gen_frac #(
    parameter int unsigned DIV_W    = 16,
    parameter int unsigned FRAC_W   = 4,
    parameter int unsigned OVS      = 16,
    parameter int unsigned DEF_INT  = 54,
    parameter int unsigned DEF_FRAC = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en_i,
    input  logic [DIV_W-1:0]  div_int_i,
    input  logic [FRAC_W-1:0] div_frac_i,
    input  logic              load_i,
    input  logic              restart_i,
    output logic              sample_tick_o,
    output logic              bit_tick_o,
    output logic              mid_tick_o,
    output logic              load_pending_o
);

    localparam int unsigned OVS_W = (OVS > 1) ? $clog2(OVS) : 1;
    localparam logic [OVS_W-1:0]  OVS_LAST = OVS_W'(OVS - 1);
    localparam logic [OVS_W-1:0]  OVS_MID  = OVS_W'(OVS / 2 - 1);
    localparam logic [DIV_W-1:0]  RST_INT  = DIV_W'(DEF_INT);
    localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(DEF_FRAC);

    logic [DIV_W-1:0]  a_int_q,  a_int_d;
    logic [FRAC_W-1:0] a_frac_q, a_frac_d;
    logic [DIV_W-1:0]  s_int_q,  s_int_d;
    logic [FRAC_W-1:0] s_frac_q, s_frac_d;
    logic              pend_q,   pend_d;
    logic [DIV_W-1:0]  cnt_q,    cnt_d;
    logic [FRAC_W-1:0] acc_q,    acc_d;
    logic              ext_q,    ext_d;
    logic [OVS_W-1:0]  ovs_q,    ovs_d;
    logic              sample_q, sample_d;
    logic              bit_q,    bit_d;
    logic              mid_q,    mid_d;

    logic [DIV_W-1:0]  eff_int;
    logic [DIV_W-1:0]  term;
    logic              at_term;
    logic [FRAC_W:0]   frac_sum;

    // Period terminal count; divisors below 2 behave as 2.
    always_comb begin
        eff_int  = (a_int_q < DIV_W'(2)) ? DIV_W'(2) : a_int_q;
        term     = eff_int - DIV_W'(1) + DIV_W'(ext_q);
        // >= rather than == so a smaller divisor loaded directly while the
        // counter is frozen past the new terminal still closes the period.
        at_term  = (cnt_q >= term);
        frac_sum = {1'b0, acc_q} + {1'b0, a_frac_q};
    end

    // Next-state and tick logic.
    always_comb begin
        a_int_d  = a_int_q;
        a_frac_d = a_frac_q;
        s_int_d  = s_int_q;
        s_frac_d = s_frac_q;
        pend_d   = pend_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        ext_d    = ext_q;
        ovs_d    = ovs_q;
        sample_d = 1'b0;
        bit_d    = 1'b0;
        mid_d    = 1'b0;

        if (restart_i) begin
            cnt_d = '0;
            acc_d = '0;
            ext_d = 1'b0;
            ovs_d = '0;
            if (load_i) begin
                a_int_d  = div_int_i;
                a_frac_d = div_frac_i;
            end else if (pend_q) begin
                a_int_d  = s_int_q;
                a_frac_d = s_frac_q;
            end
            pend_d = 1'b0;
        end else if (!en_i) begin
            // Idle generator: a new divisor can be taken on directly.
            if (load_i) begin
                a_int_d  = div_int_i;
                a_frac_d = div_frac_i;
                pend_d   = 1'b0;
            end
        end else if (at_term) begin
            cnt_d          = '0;
            {ext_d, acc_d} = frac_sum;
            sample_d       = 1'b1;
            ovs_d          = ovs_q + OVS_W'(1);
            bit_d          = (ovs_q == OVS_LAST);
            mid_d          = (ovs_q == OVS_MID);
            // A load on the boundary edge supersedes any older shadow value.
            if (load_i) begin
                a_int_d  = div_int_i;
                a_frac_d = div_frac_i;
            end else if (pend_q) begin
                a_int_d  = s_int_q;
                a_frac_d = s_frac_q;
            end
            pend_d = 1'b0;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
            if (load_i) begin
                s_int_d  = div_int_i;
                s_frac_d = div_frac_i;
                pend_d   = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_int_q  <= RST_INT;
            a_frac_q <= RST_FRAC;
            s_int_q  <= '0;
            s_frac_q <= '0;
            pend_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            ext_q    <= 1'b0;
            ovs_q    <= '0;
            sample_q <= 1'b0;
            bit_q    <= 1'b0;
            mid_q    <= 1'b0;
        end else begin
            a_int_q  <= a_int_d;
            a_frac_q <= a_frac_d;
            s_int_q  <= s_int_d;
            s_frac_q <= s_frac_d;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            ext_q    <= ext_d;
            ovs_q    <= ovs_d;
            sample_q <= sample_d;
            bit_q    <= bit_d;
            mid_q    <= mid_d;
        end
    end

    assign sample_tick_o  = sample_q;
    assign bit_tick_o     = bit_q;
    assign mid_tick_o     = mid_q;
    assign load_pending_o = pend_q;

endmodule
